// File: rtl/decode_ctrl_stage_pkg.sv
// Shared types for the RV32I(+M) decode/control stage: control word layout,
// ALU/branch/memory-size enumerations, opcode constants and op-class helpers.
package decode_ctrl_stage_pkg;

    typedef logic [31:0] instruction_type;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } encoding_type;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_LUI    = 5'd10,
        ALU_MUL    = 5'd11,
        ALU_MULH   = 5'd12,
        ALU_MULHSU = 5'd13,
        ALU_MULHU  = 5'd14,
        ALU_DIV    = 5'd15,
        ALU_DIVU   = 5'd16,
        ALU_REM    = 5'd17,
        ALU_REMU   = 5'd18
    } alu_op_type;

    // Values match the branch funct3 field.
    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_cond_type;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_type;

    typedef struct packed {
        encoding_type    encoding;
        logic            reg_write;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        mem_size_type    mem_size;
        logic            mem_unsigned;
        logic            branch;
        logic            jump;
        branch_cond_type branch_cond;
        alu_op_type      alu_op;
    } control_type;

    function automatic logic is_mul_op(input alu_op_type op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div_op(input alu_op_type op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/decode_ctrl_stage_instr_decoder.sv
// Purely combinational RV32I(+M) instruction decoder: control word, illegal
// flag, register-field extraction and source-register usage.
module instr_decoder
    import decode_ctrl_stage_pkg::*;
#(
    parameter int ENABLE_M = 1
) (
    input  instruction_type instruction,
    output control_type     control,
    output logic            illegal,
    output logic            uses_rs1,
    output logic            uses_rs2,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    control_type ctl_s;
    logic        illegal_s;
    logic        use1_s;
    logic        use2_s;

    assign opcode_s = instruction[6:0];
    assign funct3_s = instruction[14:12];
    assign funct7_s = instruction[31:25];
    assign rd       = instruction[11:7];
    assign rs1      = instruction[19:15];
    assign rs2      = instruction[24:20];

    // Decode opcode/funct3/funct7 into control fields and detect illegal encodings.
    always_comb begin
        ctl_s     = '0;
        ctl_s.alu_op = ALU_ADD;
        illegal_s = 1'b0;
        use1_s    = 1'b0;
        use2_s    = 1'b0;
        case (opcode_s)
            OP: begin
                ctl_s.encoding  = R_TYPE;
                ctl_s.reg_write = 1'b1;
                use1_s          = 1'b1;
                use2_s          = 1'b1;
                case (funct7_s)
                    7'h00: begin
                        case (funct3_s)
                            3'b000:  ctl_s.alu_op = ALU_ADD;
                            3'b001:  ctl_s.alu_op = ALU_SLL;
                            3'b010:  ctl_s.alu_op = ALU_SLT;
                            3'b011:  ctl_s.alu_op = ALU_SLTU;
                            3'b100:  ctl_s.alu_op = ALU_XOR;
                            3'b101:  ctl_s.alu_op = ALU_SRL;
                            3'b110:  ctl_s.alu_op = ALU_OR;
                            3'b111:  ctl_s.alu_op = ALU_AND;
                            default: illegal_s = 1'b1;
                        endcase
                    end
                    7'h20: begin
                        if (funct3_s == 3'b000) begin
                            ctl_s.alu_op = ALU_SUB;
                        end else if (funct3_s == 3'b101) begin
                            ctl_s.alu_op = ALU_SRA;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    7'h01: begin
                        if (ENABLE_M != 0) begin
                            case (funct3_s)
                                3'b000:  ctl_s.alu_op = ALU_MUL;
                                3'b001:  ctl_s.alu_op = ALU_MULH;
                                3'b010:  ctl_s.alu_op = ALU_MULHSU;
                                3'b011:  ctl_s.alu_op = ALU_MULHU;
                                3'b100:  ctl_s.alu_op = ALU_DIV;
                                3'b101:  ctl_s.alu_op = ALU_DIVU;
                                3'b110:  ctl_s.alu_op = ALU_REM;
                                3'b111:  ctl_s.alu_op = ALU_REMU;
                                default: illegal_s = 1'b1;
                            endcase
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OP_IMM: begin
                ctl_s.encoding  = I_TYPE;
                ctl_s.reg_write = 1'b1;
                ctl_s.alu_src   = 1'b1;
                use1_s          = 1'b1;
                case (funct3_s)
                    3'b000: ctl_s.alu_op = ALU_ADD;
                    3'b010: ctl_s.alu_op = ALU_SLT;
                    3'b011: ctl_s.alu_op = ALU_SLTU;
                    3'b100: ctl_s.alu_op = ALU_XOR;
                    3'b110: ctl_s.alu_op = ALU_OR;
                    3'b111: ctl_s.alu_op = ALU_AND;
                    3'b001: begin
                        ctl_s.alu_op = ALU_SLL;
                        illegal_s    = (funct7_s != 7'h00);
                    end
                    3'b101: begin
                        if (funct7_s == 7'h00) begin
                            ctl_s.alu_op = ALU_SRL;
                        end else if (funct7_s == 7'h20) begin
                            ctl_s.alu_op = ALU_SRA;
                        end else begin
                            illegal_s = 1'b1;
                        end
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            LOAD: begin
                ctl_s.encoding   = I_TYPE;
                ctl_s.reg_write  = 1'b1;
                ctl_s.alu_src    = 1'b1;
                ctl_s.mem_read   = 1'b1;
                ctl_s.mem_to_reg = 1'b1;
                use1_s           = 1'b1;
                case (funct3_s)
                    3'b000: ctl_s.mem_size = MEM_BYTE;
                    3'b001: ctl_s.mem_size = MEM_HALF;
                    3'b010: ctl_s.mem_size = MEM_WORD;
                    3'b100: begin
                        ctl_s.mem_size     = MEM_BYTE;
                        ctl_s.mem_unsigned = 1'b1;
                    end
                    3'b101: begin
                        ctl_s.mem_size     = MEM_HALF;
                        ctl_s.mem_unsigned = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            STORE: begin
                ctl_s.encoding  = S_TYPE;
                ctl_s.alu_src   = 1'b1;
                ctl_s.mem_write = 1'b1;
                use1_s          = 1'b1;
                use2_s          = 1'b1;
                case (funct3_s)
                    3'b000:  ctl_s.mem_size = MEM_BYTE;
                    3'b001:  ctl_s.mem_size = MEM_HALF;
                    3'b010:  ctl_s.mem_size = MEM_WORD;
                    default: illegal_s = 1'b1;
                endcase
            end
            BRANCH: begin
                ctl_s.encoding = B_TYPE;
                ctl_s.branch   = 1'b1;
                use1_s         = 1'b1;
                use2_s         = 1'b1;
                // funct3 010/011 are reserved branch encodings.
                case (funct3_s)
                    3'b000: begin ctl_s.alu_op = ALU_SUB;  ctl_s.branch_cond = BR_EQ;  end
                    3'b001: begin ctl_s.alu_op = ALU_SUB;  ctl_s.branch_cond = BR_NE;  end
                    3'b100: begin ctl_s.alu_op = ALU_SLT;  ctl_s.branch_cond = BR_LT;  end
                    3'b101: begin ctl_s.alu_op = ALU_SLT;  ctl_s.branch_cond = BR_GE;  end
                    3'b110: begin ctl_s.alu_op = ALU_SLTU; ctl_s.branch_cond = BR_LTU; end
                    3'b111: begin ctl_s.alu_op = ALU_SLTU; ctl_s.branch_cond = BR_GEU; end
                    default: illegal_s = 1'b1;
                endcase
            end
            JAL: begin
                ctl_s.encoding  = J_TYPE;
                ctl_s.reg_write = 1'b1;
                ctl_s.jump      = 1'b1;
            end
            JALR: begin
                ctl_s.encoding  = I_TYPE;
                ctl_s.reg_write = 1'b1;
                ctl_s.jump      = 1'b1;
                ctl_s.alu_src   = 1'b1;
                use1_s          = 1'b1;
                illegal_s       = (funct3_s != 3'b000);
            end
            LUI: begin
                ctl_s.encoding  = U_TYPE;
                ctl_s.reg_write = 1'b1;
                ctl_s.alu_src   = 1'b1;
                ctl_s.alu_op    = ALU_LUI;
            end
            AUIPC: begin
                ctl_s.encoding  = U_TYPE;
                ctl_s.reg_write = 1'b1;
                ctl_s.alu_src   = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // An illegal instruction carries an all-zero control word so nothing downstream acts on it.
    assign control  = illegal_s ? '0 : ctl_s;
    assign illegal  = illegal_s;
    assign uses_rs1 = use1_s & ~illegal_s;
    assign uses_rs2 = use2_s & ~illegal_s;

endmodule

// File: rtl/decode_ctrl_stage.sv
// Registered decode/control stage between IF/ID and ID/EX: valid/ready
// handshakes, flush, load-use bubble insertion and mul/div issue blocking.
module decode_ctrl_stage
    import decode_ctrl_stage_pkg::*;
#(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 1,
    parameter int DIV_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  instruction_type instruction,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output control_type     control,
    output logic            illegal
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 32'sd1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 32'sd1);
    localparam logic MUL_BLOCKS = (MUL_CYCLES > 32'sd1);
    localparam logic DIV_BLOCKS = (DIV_CYCLES > 32'sd1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } block_state_type;

    control_type     dec_control_s;
    logic            dec_illegal_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic [4:0]      rd_s;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic            hazard_s;
    logic            blocked_s;
    logic            held_s;
    logic            in_ready_s;
    logic            accept_s;
    block_state_type state_r;
    block_state_type state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    control_type     control_r;
    logic            illegal_r;
    logic            out_valid_r;
    logic [4:0]      rd_r;

    instr_decoder #(
        .ENABLE_M (ENABLE_M)
    ) u_decoder (
        .instruction (instruction),
        .control     (dec_control_s),
        .illegal     (dec_illegal_s),
        .uses_rs1    (uses_rs1_s),
        .uses_rs2    (uses_rs2_s),
        .rd          (rd_s),
        .rs1         (rs1_s),
        .rs2         (rs2_s)
    );

    // A held load whose result the incoming instruction reads must drain before issue.
    assign hazard_s = out_valid_r && control_r.mem_read && (rd_r != 5'd0) &&
                      ((uses_rs1_s && (rs1_s == rd_r)) || (uses_rs2_s && (rs2_s == rd_r)));
    assign blocked_s  = (state_r == BLOCK);
    assign held_s     = out_valid_r && !out_ready;
    assign in_ready_s = !hazard_s && !blocked_s && !held_s && !flush;
    assign accept_s   = in_valid && in_ready_s;

    // Issue-block FSM next state: multi-cycle mul/div keep the issue slot closed.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s && DIV_BLOCKS && is_div_op(dec_control_s.alu_op)) begin
                    state_s = BLOCK;
                    cnt_s   = DIV_LOAD;
                end else if (accept_s && MUL_BLOCKS && is_mul_op(dec_control_s.alu_op)) begin
                    state_s = BLOCK;
                    cnt_s   = MUL_LOAD;
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            BLOCK: begin
                // The divider handles its own cancel; the stage just reopens issue.
                if (flush || (cnt_r <= CNT_ONE)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    state_s = BLOCK;
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // Issue-block FSM state and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Output register: flush beats hold, hold beats load; no accept loads a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            control_r   <= '0;
            illegal_r   <= 1'b0;
            rd_r        <= 5'd0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (held_s) begin
            out_valid_r <= out_valid_r;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            control_r   <= dec_control_s;
            illegal_r   <= dec_illegal_s;
            rd_r        <= rd_s;
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign control   = control_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed self-checking bench for decode_ctrl_stage. Two instances share the
// stimulus: one with the M extension (DIV_CYCLES=4), one without it.
module tb_decode_ctrl_stage;
    import decode_ctrl_stage_pkg::*;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A283;
    localparam logic [31:0] I_ADD2 = 32'h00528333;
    localparam logic [31:0] I_DIV  = 32'h0220C3B3;
    localparam logic [31:0] I_BAD7 = 32'h402091B3;
    localparam logic [31:0] I_ONES = 32'hFFFFFFFF;
    localparam logic [31:0] I_BLTU = 32'h0020E463;
    localparam logic [31:0] I_NOP  = 32'h00000013;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        out_ready;
    logic [31:0] instruction;
    logic        in_ready;
    logic        out_valid;
    control_type control;
    logic        illegal;
    logic        nm_in_ready;
    logic        nm_out_valid;
    control_type nm_control;
    logic        nm_illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    decode_ctrl_stage #(
        .ENABLE_M   (1),
        .MUL_CYCLES (1),
        .DIV_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .control     (control),
        .illegal     (illegal)
    );

    decode_ctrl_stage #(
        .ENABLE_M   (0),
        .MUL_CYCLES (1),
        .DIV_CYCLES (4)
    ) dut_nom (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (nm_in_ready),
        .instruction (instruction),
        .flush       (flush),
        .out_valid   (nm_out_valid),
        .out_ready   (out_ready),
        .control     (nm_control),
        .illegal     (nm_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; instruction = I_NOP;
        tick(); tick();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_control", control, '0);
        check("rst_illegal", illegal, 1'b0);
        rst = 1'b0; #1;
        check("rst_in_ready", in_ready, 1'b1);

        // add x3,x1,x2
        instruction = I_ADD; in_valid = 1'b1; #1;
        check("add_in_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        check("add_out_valid", out_valid, 1'b1);
        check("add_alu_op", control.alu_op, ALU_ADD);
        check("add_reg_write", control.reg_write, 1'b1);
        check("add_alu_src", control.alu_src, 1'b0);
        check("add_encoding", control.encoding, R_TYPE);
        check("add_illegal", illegal, 1'b0);

        // lw x5,0(x1) followed by dependent add x6,x5,x5
        tick();
        instruction = I_LW; in_valid = 1'b1; #1;
        check("lw_in_ready", in_ready, 1'b1);
        tick();
        instruction = I_ADD2; #1;
        check("lw_out_valid", out_valid, 1'b1);
        check("lw_mem_read", control.mem_read, 1'b1);
        check("lw_mem_size", control.mem_size, MEM_WORD);
        check("lw_mem_to_reg", control.mem_to_reg, 1'b1);
        check("lu_stall", in_ready, 1'b0);
        tick(); #1;
        check("lu_bubble", out_valid, 1'b0);
        check("lu_ready_again", in_ready, 1'b1);
        tick(); in_valid = 1'b0;
        check("lu_add_valid", out_valid, 1'b1);
        check("lu_add_mem_read", control.mem_read, 1'b0);
        check("lu_add_reg_write", control.reg_write, 1'b1);

        // div x7,x1,x2 blocks issue for 3 further cycles; illegal without M
        tick();
        instruction = I_DIV; in_valid = 1'b1; #1;
        check("div_in_ready", in_ready, 1'b1);
        tick(); in_valid = 1'b0; #1;
        check("div_out_valid", out_valid, 1'b1);
        check("div_alu_op", control.alu_op, ALU_DIV);
        check("div_illegal", illegal, 1'b0);
        check("div_block_0", in_ready, 1'b0);
        check("nom_div_illegal", nm_illegal, 1'b1);
        check("nom_div_valid", nm_out_valid, 1'b1);
        check("nom_div_reg_write", nm_control.reg_write, 1'b0);
        check("nom_div_no_block", nm_in_ready, 1'b1);
        for (int i = 1; i < 3; i++) begin
            tick();
            check($sformatf("div_block_%0d", i), in_ready, 1'b0);
        end
        tick();
        check("div_unblock", in_ready, 1'b1);

        // Illegal encodings
        instruction = I_BAD7; in_valid = 1'b1;
        tick();
        instruction = I_ONES;
        check("bad7_illegal", illegal, 1'b1);
        check("bad7_valid", out_valid, 1'b1);
        check("bad7_enables", {control.reg_write, control.mem_write, control.mem_read, control.branch, control.jump}, 5'b00000);
        tick();
        instruction = I_BLTU;
        check("ones_illegal", illegal, 1'b1);
        check("ones_enables", {control.reg_write, control.mem_write, control.mem_read, control.branch, control.jump}, 5'b00000);
        tick(); in_valid = 1'b0;
        check("bltu_illegal", illegal, 1'b0);
        check("bltu_alu_op", control.alu_op, ALU_SLTU);
        check("bltu_cond", control.branch_cond, BR_LTU);
        check("bltu_branch_regw", {control.branch, control.reg_write}, 2'b10);

        // Output hold while execute is not ready, then flush it away
        tick();
        out_ready = 1'b0; instruction = I_ADD; in_valid = 1'b1;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("hold_valid_%0d", i), out_valid, 1'b1);
            check($sformatf("hold_alu_op_%0d", i), control.alu_op, ALU_ADD);
            check($sformatf("hold_regw_%0d", i), control.reg_write, 1'b1);
            check($sformatf("hold_in_ready_%0d", i), in_ready, 1'b0);
            tick();
        end
        flush = 1'b1; #1;
        check("flush_in_ready", in_ready, 1'b0);
        tick(); flush = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", out_valid, 1'b0);

        // Flush on the second BLOCK cycle reopens issue immediately
        instruction = I_DIV; in_valid = 1'b1;
        tick(); in_valid = 1'b0; #1;
        check("fb_block_1", in_ready, 1'b0);
        tick(); flush = 1'b1; #1;
        check("fb_flush_ready", in_ready, 1'b0);
        tick(); flush = 1'b0; #1;
        check("fb_ready", in_ready, 1'b1);
        check("fb_out_valid", out_valid, 1'b0);

        // Reset in the middle of a stream, with the FSM in BLOCK
        instruction = I_ADD; in_valid = 1'b1;
        tick();
        instruction = I_DIV;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_control", control, '0);
        check("mid_rst_illegal", illegal, 1'b0);
        check("mid_rst_in_ready", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
